// File: rtl/mc_ctrl.sv
// -----------------------------------------------------------------------------
// mc_ctrl -- multi-cycle MIPS-subset control unit.
//
// Sequences each instruction through FETCH -> DECODE -> EXEC -> MEM -> WB,
// skipping the phases an instruction does not need, and drives the datapath
// control lines combinationally from the current state and instruction fields.
//
// Parameter
//   WAIT_MEM   1: MEM holds until mem_ready=1; 0: MEM always lasts one cycle.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   reset      synchronous active-high reset
//   op         IR[31:26], held stable by the datapath after FETCH
//   funct      IR[5:0]
//   zero       ALU equal flag (beq condition)
//   mem_ready  data memory has completed the access
//   pc_wr      PC write strobe
//   npc_sel    next PC: 00 PC+4, 01 branch target, 10 j/jal target, 11 rs
//   ir_wr      IR write strobe
//   reg_wr     register file write strobe
//   reg_dst    write register: 00 rt, 01 rd, 10 $31
//   wd_sel     write data: 00 ALU, 01 memory, 10 PC register (link)
//   alu_src    ALU B operand: 0 rt, 1 extended immediate
//   alu_op     000 add, 001 sub, 010 or, 011 pass B
//   ext_op     00 zero-extend, 01 sign-extend, 10 imm<<16
//   mem_rd     data memory read strobe
//   mem_wr     data memory write strobe
//   state      current FSM state (debug / checker visibility)
//   illegal    one-cycle pulse in DECODE for an unsupported instruction
//   instr_cnt  retired instruction count (wraps)
//
// Memory handshake: mem_rd / mem_wr act as the request and stay high for
// every cycle spent in MEM; the access completes on the cycle mem_ready=1 is
// sampled with a request high (with WAIT_MEM=0 mem_ready is ignored and the
// access is taken as complete after one cycle).
// -----------------------------------------------------------------------------
module mc_ctrl #(
  parameter bit WAIT_MEM = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_wr,
  output logic [1:0]  npc_sel,
  output logic        ir_wr,
  output logic        reg_wr,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wd_sel,
  output logic        alu_src,
  output logic [2:0]  alu_op,
  output logic [1:0]  ext_op,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] instr_cnt
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_NOP   = 6'b000000;

  logic [2:0]  state_q, state_nxt;
  logic [31:0] cnt_q;

  // Instruction decode
  logic is_r, is_addu, is_subu, is_jr, is_nop;
  logic is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal, is_legal;

  assign is_r     = (op == OP_RTYPE);
  assign is_addu  = is_r && (funct == FN_ADDU);
  assign is_subu  = is_r && (funct == FN_SUBU);
  assign is_jr    = is_r && (funct == FN_JR);
  assign is_nop   = is_r && (funct == FN_NOP);
  assign is_ori   = (op == OP_ORI);
  assign is_lui   = (op == OP_LUI);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_beq   = (op == OP_BEQ);
  assign is_j     = (op == OP_J);
  assign is_jal   = (op == OP_JAL);
  assign is_legal = is_addu | is_subu | is_jr | is_nop | is_ori | is_lui |
                    is_lw | is_sw | is_beq | is_j | is_jal;

  // Raw (pre-reset-gating) control values
  logic       pc_wr_c, ir_wr_c, reg_wr_c, mem_rd_c, mem_wr_c, illegal_c;
  logic [1:0] npc_sel_c, reg_dst_c, wd_sel_c, ext_op_c;
  logic       alu_src_c;
  logic [2:0] alu_op_c;

  always_comb begin
    state_nxt = state_q;
    pc_wr_c   = 1'b0;
    npc_sel_c = 2'b00;
    ir_wr_c   = 1'b0;
    reg_wr_c  = 1'b0;
    reg_dst_c = 2'b00;
    wd_sel_c  = 2'b00;
    alu_src_c = 1'b0;
    alu_op_c  = 3'b000;
    ext_op_c  = 2'b00;
    mem_rd_c  = 1'b0;
    mem_wr_c  = 1'b0;
    illegal_c = 1'b0;

    case (state_q)
      S_FETCH: begin
        ir_wr_c   = 1'b1;
        pc_wr_c   = 1'b1;
        npc_sel_c = 2'b00;
        state_nxt = S_DECODE;
      end

      S_DECODE: begin
        state_nxt = S_FETCH;
        if (is_j) begin
          pc_wr_c   = 1'b1;
          npc_sel_c = 2'b10;
        end else if (is_jal) begin
          // PC register already holds PC+4, so link and jump together.
          pc_wr_c   = 1'b1;
          npc_sel_c = 2'b10;
          reg_wr_c  = 1'b1;
          reg_dst_c = 2'b10;
          wd_sel_c  = 2'b10;
        end else if (is_jr) begin
          pc_wr_c   = 1'b1;
          npc_sel_c = 2'b11;
        end else if (is_nop) begin
          state_nxt = S_FETCH;
        end else if (!is_legal) begin
          illegal_c = 1'b1;
        end else begin
          state_nxt = S_EXEC;
        end
      end

      S_EXEC: begin
        state_nxt = S_FETCH;
        if (is_beq) begin
          alu_op_c  = 3'b001;
          alu_src_c = 1'b0;
          ext_op_c  = 2'b01;
          pc_wr_c   = zero;
          npc_sel_c = 2'b01;
        end else if (is_addu) begin
          alu_op_c  = 3'b000;
          state_nxt = S_WB;
        end else if (is_subu) begin
          alu_op_c  = 3'b001;
          state_nxt = S_WB;
        end else if (is_ori) begin
          alu_op_c  = 3'b010;
          alu_src_c = 1'b1;
          ext_op_c  = 2'b00;
          state_nxt = S_WB;
        end else if (is_lui) begin
          alu_op_c  = 3'b011;
          alu_src_c = 1'b1;
          ext_op_c  = 2'b10;
          state_nxt = S_WB;
        end else if (is_lw || is_sw) begin
          alu_op_c  = 3'b000;
          alu_src_c = 1'b1;
          ext_op_c  = 2'b01;
          state_nxt = S_MEM;
        end
      end

      S_MEM: begin
        mem_rd_c = is_lw;
        mem_wr_c = is_sw;
        if (!WAIT_MEM || mem_ready) begin
          state_nxt = is_lw ? S_WB : S_FETCH;
        end
      end

      S_WB: begin
        state_nxt = S_FETCH;
        if (is_addu || is_subu) begin
          reg_wr_c  = 1'b1;
          reg_dst_c = 2'b01;
          wd_sel_c  = 2'b00;
        end else if (is_ori || is_lui) begin
          reg_wr_c  = 1'b1;
          reg_dst_c = 2'b00;
          wd_sel_c  = 2'b00;
        end else if (is_lw) begin
          reg_wr_c  = 1'b1;
          reg_dst_c = 2'b00;
          wd_sel_c  = 2'b01;
        end
      end

      default: state_nxt = S_FETCH;  // unused encodings recover with no strobes
    endcase
  end

  // An instruction retires when it returns to FETCH from a working state,
  // unless it was rejected as illegal. Unused encodings do not count.
  logic retire;
  assign retire = (state_q == S_DECODE || state_q == S_EXEC ||
                   state_q == S_MEM    || state_q == S_WB) &&
                  (state_nxt == S_FETCH) && !illegal_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_nxt;
      if (retire) cnt_q <= cnt_q + 32'd1;
    end
  end

  // Reset squashes every write strobe so an interrupted instruction has no
  // further side effects, even mid-MEM.
  assign pc_wr     = pc_wr_c   & ~reset;
  assign ir_wr     = ir_wr_c   & ~reset;
  assign reg_wr    = reg_wr_c  & ~reset;
  assign mem_rd    = mem_rd_c  & ~reset;
  assign mem_wr    = mem_wr_c  & ~reset;
  assign illegal   = illegal_c & ~reset;
  assign npc_sel   = npc_sel_c;
  assign reg_dst   = reg_dst_c;
  assign wd_sel    = wd_sel_c;
  assign alu_src   = alu_src_c;
  assign alu_op    = alu_op_c;
  assign ext_op    = ext_op_c;
  assign state     = state_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl -- self-checking bench for mc_ctrl.
//
// The reference model walks each instruction through the phases its class
// needs and writes down, cycle by cycle, what every output must be. Those
// records go into exp_q (with a care-mask in msk_q); one compare process at
// the falling edge pops a record per cycle and checks the DUT. A second queue
// carries hand-computed literal expectations (instr_cnt, state, MEM length).
// -----------------------------------------------------------------------------
module tb_mc_ctrl;

  localparam bit WAIT_MEM = 1'b1;
  localparam int W = 53;

  // Record layout: state[52:50] pc_wr[49] npc_sel[48:47] ir_wr[46] reg_wr[45]
  // reg_dst[44:43] wd_sel[42:41] alu_src[40] alu_op[39:37] ext_op[36:35]
  // mem_rd[34] mem_wr[33] illegal[32] instr_cnt[31:0]

  // Instruction classes
  localparam int K_ILL = 0, K_ADDU = 1, K_SUBU = 2, K_JR = 3, K_NOP = 4,
                 K_ORI = 5, K_LUI = 6, K_LW = 7, K_SW = 8, K_BEQ = 9,
                 K_J = 10, K_JAL = 11;

  logic        clk;
  logic        reset;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic        pc_wr;
  logic [1:0]  npc_sel;
  logic        ir_wr;
  logic        reg_wr;
  logic [1:0]  reg_dst;
  logic [1:0]  wd_sel;
  logic        alu_src;
  logic [2:0]  alu_op;
  logic [1:0]  ext_op;
  logic        mem_rd;
  logic        mem_wr;
  logic [2:0]  state;
  logic        illegal;
  logic [31:0] instr_cnt;

  mc_ctrl #(.WAIT_MEM(WAIT_MEM)) dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .funct     (funct),
    .zero      (zero),
    .mem_ready (mem_ready),
    .pc_wr     (pc_wr),
    .npc_sel   (npc_sel),
    .ir_wr     (ir_wr),
    .reg_wr    (reg_wr),
    .reg_dst   (reg_dst),
    .wd_sel    (wd_sel),
    .alu_src   (alu_src),
    .alu_op    (alu_op),
    .ext_op    (ext_op),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .state     (state),
    .illegal   (illegal),
    .instr_cnt (instr_cnt)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] msk_q[$];
  logic [33:0]  lit_q[$];   // [33:32] kind: 0 instr_cnt, 1 state, 2 mem_rd cycles
  int tests = 0;
  int fails = 0;
  int rd_cycles = 0;

  // Expected fields for the cycle being built
  logic [2:0]  e_st;
  logic        e_pcw, e_irw, e_rgw, e_src, e_mrd, e_mwr, e_ill;
  logic [1:0]  e_npc, e_dst, e_wd, e_ext;
  logic [2:0]  e_aop;
  logic        m_alu, m_ext;
  logic [31:0] mcnt;

  function automatic logic [W-1:0] pack(
    input logic [2:0] st, input logic pcw, input logic [1:0] npc,
    input logic irw, input logic rgw, input logic [1:0] dst,
    input logic [1:0] wd, input logic src, input logic [2:0] aop,
    input logic [1:0] ext, input logic mrd, input logic mwr,
    input logic ill, input logic [31:0] cnt);
    return {st, pcw, npc, irw, rgw, dst, wd, src, aop, ext, mrd, mwr, ill, cnt};
  endfunction

  function automatic int kind_of(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'h00: begin
        case (f)
          6'h21:   return K_ADDU;
          6'h23:   return K_SUBU;
          6'h08:   return K_JR;
          6'h00:   return K_NOP;
          default: return K_ILL;
        endcase
      end
      6'h0d:   return K_ORI;
      6'h0f:   return K_LUI;
      6'h23:   return K_LW;
      6'h2b:   return K_SW;
      6'h04:   return K_BEQ;
      6'h02:   return K_J;
      6'h03:   return K_JAL;
      default: return K_ILL;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clr(input logic [2:0] st);
    e_st = st;  e_pcw = 0; e_npc = 0; e_irw = 0; e_rgw = 0; e_dst = 0;
    e_wd = 0;   e_src = 0; e_aop = 0; e_ext = 0; e_mrd = 0; e_mwr = 0;
    e_ill = 0;  m_alu = 0; m_ext = 0;
  endtask

  // Drive one cycle's inputs, record what the outputs must be, advance.
  task automatic step(input logic mr, input logic rst);
    logic [1:0] mn, mr2;
    reset     = rst;
    mem_ready = mr;
    mn  = e_pcw ? 2'b11 : 2'b00;
    mr2 = e_rgw ? 2'b11 : 2'b00;
    exp_q.push_back(pack(e_st, e_pcw, e_npc, e_irw, e_rgw, e_dst, e_wd, e_src,
                         e_aop, e_ext, e_mrd, e_mwr, e_ill, mcnt));
    msk_q.push_back(pack(3'h7, 1'b1, mn, 1'b1, 1'b1, mr2, mr2, m_alu,
                         m_alu ? 3'h7 : 3'h0, m_ext ? 2'h3 : 2'h0,
                         1'b1, 1'b1, 1'b1, 32'hffff_ffff));
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input logic [1:0] kind, input logic [31:0] val);
    lit_q.push_back({kind, val});
  endtask

  // One instruction. abort_at >= 0 asserts reset on that MEM cycle.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                           input logic z, input int waits, input int abort_at);
    int k;
    int n;
    k     = kind_of(o, f);
    op    = o;
    funct = f;
    zero  = z;

    // FETCH
    clr(3'd0); e_irw = 1; e_pcw = 1; e_npc = 2'b00;
    step(1'($urandom_range(0, 1)), 1'b0);

    // DECODE
    clr(3'd1);
    case (k)
      K_J:   begin e_pcw = 1; e_npc = 2'b10; end
      K_JAL: begin e_pcw = 1; e_npc = 2'b10; e_rgw = 1; e_dst = 2'b10; e_wd = 2'b10; end
      K_JR:  begin e_pcw = 1; e_npc = 2'b11; end
      K_ILL: e_ill = 1;
      default: ;
    endcase
    step(1'($urandom_range(0, 1)), 1'b0);
    if (k == K_ILL) return;
    if (k == K_J || k == K_JAL || k == K_JR || k == K_NOP) begin
      mcnt = mcnt + 1;
      return;
    end

    // EXEC
    clr(3'd2); m_alu = 1;
    case (k)
      K_BEQ:  begin e_aop = 3'b001; e_ext = 2'b01; m_ext = 1;
                    e_pcw = z; e_npc = 2'b01; end
      K_ADDU: e_aop = 3'b000;
      K_SUBU: e_aop = 3'b001;
      K_ORI:  begin e_aop = 3'b010; e_src = 1; e_ext = 2'b00; m_ext = 1; end
      K_LUI:  begin e_aop = 3'b011; e_src = 1; e_ext = 2'b10; m_ext = 1; end
      default: begin e_aop = 3'b000; e_src = 1; e_ext = 2'b01; m_ext = 1; end
    endcase
    step(1'($urandom_range(0, 1)), 1'b0);
    if (k == K_BEQ) begin
      mcnt = mcnt + 1;
      return;
    end

    // MEM
    if (k == K_LW || k == K_SW) begin
      n = WAIT_MEM ? waits + 1 : 1;
      for (int i = 0; i < n; i++) begin
        clr(3'd3);
        if (i == abort_at) begin
          // Reset mid-access: nothing written, instruction not counted.
          step(1'b0, 1'b1);
          mcnt = 0;
          return;
        end
        e_mrd = (k == K_LW);
        e_mwr = (k == K_SW);
        step(i == n - 1, 1'b0);
      end
      if (k == K_SW) begin
        mcnt = mcnt + 1;
        return;
      end
    end

    // WB
    clr(3'd4); e_rgw = 1;
    e_dst = (k == K_ADDU || k == K_SUBU) ? 2'b01 : 2'b00;
    e_wd  = (k == K_LW) ? 2'b01 : 2'b00;
    step(1'($urandom_range(0, 1)), 1'b0);
    mcnt = mcnt + 1;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [W-1:0] e, m, a;
    logic [33:0]  l;
    logic [31:0]  act;
    if (mem_rd === 1'b1) rd_cycles = rd_cycles + 1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      a = pack(state, pc_wr, npc_sel, ir_wr, reg_wr, reg_dst, wd_sel, alu_src,
               alu_op, ext_op, mem_rd, mem_wr, illegal, instr_cnt);
      tests = tests + 1;
      if ((a & m) !== (e & m)) begin
        fails = fails + 1;
        $display("FAIL cycle_outputs t=%0t actual=%h required=%h care=%h",
                 $time, a & m, e & m, m);
      end
    end
    while (lit_q.size() != 0) begin
      l = lit_q.pop_front();
      case (l[33:32])
        2'd0:    act = instr_cnt;
        2'd1:    act = {29'd0, state};
        default: act = rd_cycles;
      endcase
      tests = tests + 1;
      if (act !== l[31:0]) begin
        fails = fails + 1;
        $display("FAIL literal_kind%0d t=%0t actual=%0d required=%0d",
                 l[33:32], $time, act, l[31:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [5:0] legal_ops[8];
  logic [5:0] r_functs[4];

  initial begin
    int o_i, waits, abort_at;
    logic [5:0] o, f;

    legal_ops = '{6'h00, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h03};
    r_functs  = '{6'h21, 6'h23, 6'h08, 6'h00};

    // clock/reset
    reset = 1'b1; op = 6'h0; funct = 6'h0; zero = 1'b0; mem_ready = 1'b0;
    mcnt = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clr(3'd0);
    step(1'b0, 1'b1);            // in reset: FETCH, no strobes, count 0

    // Directed scenarios with hand-computed totals
    run_instr(6'h00, 6'h21, 1'b0, 0, -1);  lit(2'd0, 32'd1);   // addu
    run_instr(6'h04, 6'h00, 1'b1, 0, -1);  lit(2'd0, 32'd2);   // beq taken
    run_instr(6'h04, 6'h00, 1'b0, 0, -1);  lit(2'd0, 32'd3);   // beq not taken
    run_instr(6'h23, 6'h00, 1'b0, 3, -1);  lit(2'd0, 32'd4);   // lw, 3 wait cycles
    lit(2'd2, 32'd4);                                          // 4 cycles of mem_rd
    run_instr(6'h03, 6'h00, 1'b0, 0, -1);  lit(2'd0, 32'd5);   // jal
    run_instr(6'h3f, 6'h00, 1'b0, 0, -1);  lit(2'd0, 32'd5);   // illegal op
    run_instr(6'h00, 6'h2a, 1'b0, 0, -1);  lit(2'd0, 32'd5);   // illegal funct
    run_instr(6'h2b, 6'h00, 1'b0, 4, 2);                       // sw, reset mid-wait
    lit(2'd0, 32'd0);
    lit(2'd1, 32'd0);

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        o = 6'($urandom_range(0, 63));
        f = 6'($urandom_range(0, 63));
      end else begin
        o_i = $urandom_range(0, 7);
        o   = legal_ops[o_i];
        f   = (o == 6'h00) ? r_functs[$urandom_range(0, 3)] : 6'($urandom_range(0, 63));
      end
      waits    = $urandom_range(0, 4);
      abort_at = ($urandom_range(0, 15) == 0) ? $urandom_range(0, waits) : -1;
      run_instr(o, f, 1'($urandom_range(0, 1)), waits, abort_at);
    end
    lit(2'd0, mcnt);

    // final report
    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0 || lit_q.size() != 0) begin
      fails = fails + 1;
      $display("FAIL drain actual=%0d required=0", exp_q.size() + lit_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL have parameter WAIT_MEM, default 1: when 1, the MEM state holds until mem_ready=1; when 0, MEM always lasts one cycle.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port op, input, 6 bits: IR[31:26], held stable by the datapath after FETCH.
REQ-005 The block SHALL have port funct, input, 6 bits: IR[5:0].
REQ-006 The block SHALL have port zero, input, 1 bit: the ALU equal flag.
REQ-007 The block SHALL have port mem_ready, input, 1 bit: data memory has completed the access.
REQ-008 The block SHALL have output pc_wr, 1 bit (PC write strobe), and output npc_sel, 2 bits: 00 = PC+4, 01 = branch target, 10 = j/jal target, 11 = rs (jr).
REQ-009 The block SHALL have output ir_wr, 1 bit: IR write strobe.
REQ-010 The block SHALL have outputs reg_wr (1 bit) and reg_dst (2 bits): 00 = rt, 01 = rd, 10 = $31.
REQ-011 The block SHALL have output wd_sel, 2 bits: 00 = ALU, 01 = memory, 10 = PC register (link).
REQ-012 The block SHALL have output alu_src, 1 bit: 0 = rt, 1 = extended immediate.
REQ-013 The block SHALL have output alu_op, 3 bits: 000 = add, 001 = sub, 010 = or, 011 = pass B.
REQ-014 The block SHALL have output ext_op, 2 bits: 00 = zero-extend, 01 = sign-extend, 10 = imm<<16.
REQ-015 The block SHALL have outputs mem_rd and mem_wr, 1 bit each: data memory strobes.
REQ-016 The block SHALL have output state, 3 bits (current state), output illegal, 1 bit (one-cycle pulse), and output instr_cnt, 32 bits (retired instruction count).

Function
REQ-017 The block SHALL decode these opcodes: R-type 000000 (addu, funct 100001; subu, funct 100011; jr, funct 001000; nop, funct 000000); ori 001101; lui 001111; lw 100011; sw 101011; beq 000100; j 000010; jal 000011. Any other op/funct combination SHALL be illegal.
REQ-018 The block SHALL register only the state and instr_cnt; all other outputs SHALL be combinational in state, op, funct, zero and mem_ready.
REQ-019 The state encoding SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; any unused encoding SHALL return to FETCH on the next cycle with all strobes 0.
REQ-020 In FETCH, the block SHALL assert ir_wr=1 and pc_wr=1 with npc_sel=00, then go to DECODE.
REQ-021 In DECODE, for j, the block SHALL assert pc_wr with npc_sel=10 and go to FETCH.
REQ-022 In DECODE, for jal, the block SHALL assert pc_wr with npc_sel=10, and reg_wr with reg_dst=10 and wd_sel=10 (the PC register already holds PC+4), in the same cycle, then go to FETCH.
REQ-023 In DECODE, for jr, the block SHALL assert pc_wr with npc_sel=11 and go to FETCH.
REQ-024 In DECODE, for nop, the block SHALL go to FETCH with no strobes.
REQ-025 In DECODE, for an illegal instruction, the block SHALL pulse illegal=1 with no strobes and go to FETCH.
REQ-026 In DECODE, for all other instructions, the block SHALL go to EXEC.
REQ-027 In EXEC, for beq, the block SHALL drive alu_op=001, alu_src=0 and ext_op=01, assert pc_wr=zero with npc_sel=01, and go to FETCH.
REQ-028 In EXEC, for addu/subu, the block SHALL drive alu_op 000/001 with alu_src=0; for ori, alu_op=010, alu_src=1, ext_op=00; for lui, alu_op=011, alu_src=1, ext_op=10. All four SHALL go to WB.
REQ-029 In EXEC, for lw/sw, the block SHALL drive alu_op=000, alu_src=1, ext_op=01 and go to MEM.
REQ-030 In MEM, the block SHALL assert mem_rd (lw) or mem_wr (sw) every cycle spent there; with WAIT_MEM=1 and mem_ready=0 it SHALL stay in MEM.
REQ-031 On leaving MEM, sw SHALL go to FETCH and lw SHALL go to WB.
REQ-032 In WB, the block SHALL assert reg_wr with reg_dst=01 and wd_sel=00 for R-type, reg_dst=00 and wd_sel=00 for ori/lui, and reg_dst=00 and wd_sel=01 for lw, then go to FETCH.
REQ-033 instr_cnt SHALL increment by 1, wrapping from 0xFFFFFFFF to 0, on every transition into FETCH from DECODE, EXEC, MEM or WB, except after an illegal instruction.
REQ-034 At most one of pc_wr/ir_wr SHALL change the PC per cycle, and mem_rd and mem_wr SHALL never both be 1.

Reset
REQ-035 When reset=1 at a rising edge, the block SHALL set state=FETCH and instr_cnt=0, regardless of the current state (including mid-MEM wait).
REQ-036 While reset=1, the block SHALL force every write strobe (pc_wr, ir_wr, reg_wr, mem_wr, mem_rd) and illegal to 0.
REQ-037 An instruction interrupted by reset SHALL perform no further writes and SHALL not be counted.

Verification
REQ-038 addu (op 0, funct 0x21) after reset -> states 0,1,2,4,0; reg_wr=1 with reg_dst=01 only in WB; instr_cnt=1.
REQ-039 beq with zero=1 and again with zero=0 -> pc_wr=1 with npc_sel=01 in EXEC only when zero=1; each takes 3 cycles.
REQ-040 lw with WAIT_MEM=1 and mem_ready low for 3 cycles -> 4 MEM cycles with mem_rd=1, then WB with wd_sel=01.
REQ-041 jal -> in DECODE, pc_wr=1, npc_sel=10, reg_wr=1, reg_dst=10, wd_sel=10; back to FETCH after 2 cycles.
REQ-042 op=0x3F -> illegal pulses once in DECODE, no strobes, instr_cnt unchanged.
REQ-043 reset asserted during a sw MEM wait -> all strobes 0 that cycle; next state=FETCH; instr_cnt=0.
